// File: rtl/sobel_pkg.sv
// ---------------------------------------------------------------------------
// sobel_pkg : shared widths, output codes and arithmetic helpers for Sobel.
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sobel_pkg;

    localparam int GRAD_W   = 11;
    localparam int MAG_W    = 12;
    localparam int PIPE_LAT = 4;

    localparam logic [23:0] EDGE_ON  = 24'hFFFFFF;
    localparam logic [23:0] EDGE_OFF = 24'h000000;

    typedef logic [7:0] pix_t;

    // Side-band tag that rides alongside the data through every stage.
    typedef struct packed {
        logic valid;
        logic border;
    } tag_t;

    // 1-2-1 weighted column/row sum, 0..1020.
    function automatic logic [GRAD_W-2:0] wsum(input pix_t a, input pix_t b, input pix_t c);
        return (GRAD_W-1)'(a) + (GRAD_W-1)'({b, 1'b0}) + (GRAD_W-1)'(c);
    endfunction

    function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
        logic [GRAD_W-1:0] a;
        a = g[GRAD_W-1] ? GRAD_W'(-g) : GRAD_W'(g);
        return MAG_W'(a);
    endfunction

    function automatic pix_t sat8(input logic [MAG_W-1:0] m);
        return (m > MAG_W'(255)) ? 8'hFF : m[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sobel_linebuf.sv
// ---------------------------------------------------------------------------
// sobel_linebuf : one image-row RAM, registered read, read-before-write.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sobel_linebuf
    import sobel_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output pix_t          rd_data_o,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  pix_t          wr_data_i
);

    pix_t mem_q [0:DEPTH-1];
    pix_t rd_data_q;

    // Contents are never cleared; downstream border masking hides stale data.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/sobel_edge.sv
// ---------------------------------------------------------------------------
// sobel_edge : 3x3 Sobel |Gx|+|Gy| edge detector, 4-cycle fixed latency.
//              Define SOBEL_MAG_OUT_EN to emit saturated magnitude instead.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sobel_edge
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int THRESH = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        src_valid,
    input  logic [23:0] src_data,
    output logic        dst_valid,
    output logic [23:0] dst_data
);

    localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 2;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam int TAG_N = PIPE_LAT - 1;

    logic accept;
    logic unused_hi;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    tag_t             tag_q [0:TAG_N-1];
    pix_t             pix1_q;
    logic [COL_W-1:0] col1_q;
    pix_t             row1_rd;
    pix_t             row2_rd;
    logic             lb_b_wr_en;

    pix_t             win_q [0:2][0:2];
    logic signed [GRAD_W-1:0] gx_d, gy_d, gx_q, gy_q;
    logic [MAG_W-1:0] mag;

    logic             dst_valid_q;
    logic [23:0]      dst_data_q, dst_data_d;

    // A beat coinciding with reset is dropped entirely.
    assign accept    = src_valid & ~rst;
    assign unused_hi = ^src_data[23:8];

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            for (int i = 0; i < TAG_N; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            tag_q[0] <= '{valid: accept,
                          border: (row_q < ROW_W'(2)) || (col_q < COL_W'(2))};
            for (int i = 1; i < TAG_N; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pix1_q <= src_data[7:0];
            col1_q <= col_q;
        end
    end

    // Buffer B takes the old row-1 value one beat later, once A has read it out.
    assign lb_b_wr_en = tag_q[0].valid & ~rst;

    sobel_linebuf #(
        .DEPTH (IMG_W),
        .AW    (COL_W)
    ) u_lb_a (
        .clk       (clk),
        .rd_en_i   (accept),
        .rd_addr_i (col_q),
        .rd_data_o (row1_rd),
        .wr_en_i   (accept),
        .wr_addr_i (col_q),
        .wr_data_i (src_data[7:0])
    );

    sobel_linebuf #(
        .DEPTH (IMG_W),
        .AW    (COL_W)
    ) u_lb_b (
        .clk       (clk),
        .rd_en_i   (accept),
        .rd_addr_i (col_q),
        .rd_data_o (row2_rd),
        .wr_en_i   (lb_b_wr_en),
        .wr_addr_i (col1_q),
        .wr_data_i (row1_rd)
    );

    // Window: [row 0=top..2=bottom][col 0=left..2=right]; shifts on valid only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (tag_q[0].valid) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= row2_rd;
            win_q[1][2] <= row1_rd;
            win_q[2][2] <= pix1_q;
        end
    end

    always_comb begin
        gx_d = $signed({1'b0, wsum(win_q[0][2], win_q[1][2], win_q[2][2])})
             - $signed({1'b0, wsum(win_q[0][0], win_q[1][0], win_q[2][0])});
        gy_d = $signed({1'b0, wsum(win_q[2][0], win_q[2][1], win_q[2][2])})
             - $signed({1'b0, wsum(win_q[0][0], win_q[0][1], win_q[0][2])});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gx_q <= '0;
            gy_q <= '0;
        end else begin
            gx_q <= gx_d;
            gy_q <= gy_d;
        end
    end

    assign mag = abs_grad(gx_q) + abs_grad(gy_q);

`ifdef SOBEL_MAG_OUT_EN
    always_comb begin
        dst_data_d = EDGE_OFF;
        if (tag_q[TAG_N-1].valid && !tag_q[TAG_N-1].border) begin
            dst_data_d = {3{sat8(mag)}};
        end
    end
`else
    localparam logic [MAG_W-1:0] THRESH_C = MAG_W'(THRESH);

    always_comb begin
        dst_data_d = EDGE_OFF;
        if (tag_q[TAG_N-1].valid && !tag_q[TAG_N-1].border) begin
            dst_data_d = (mag >= THRESH_C) ? EDGE_ON : EDGE_OFF;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
        end else begin
            dst_valid_q <= tag_q[TAG_N-1].valid;
            dst_data_q  <= dst_data_d;
        end
    end

    assign dst_valid = dst_valid_q;
    assign dst_data  = dst_data_q;

endmodule

`default_nettype wire

// File: tb/tb_sobel_edge.sv
// ---------------------------------------------------------------------------
// tb_sobel_edge : randomized self-checking bench for sobel_edge (8x6 frames).
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sobel_edge;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int TH  = 100;
    localparam int LAT = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        src_valid = 1'b0;
    logic [23:0] src_data  = '0;
    logic        dst_valid;
    logic [23:0] dst_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [23:0] data;
        int          t;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] outs[$];
    logic [23:0] ref_seq[$];
    int          img [0:H-1][0:W-1];
    int          mr = 0;
    int          mc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sobel_edge #(
        .IMG_W  (W),
        .IMG_H  (H),
        .THRESH (TH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .dst_valid (dst_valid),
        .dst_data  (dst_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: direct 3x3 Sobel on the stored image, output tagged to input (r,c).
    function automatic logic [23:0] ref_pix(input int r, input int c);
        int gx, gy, mag, m;
        if (r < 2 || c < 2) return 24'h0;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_MAG_OUT_EN
        m = (mag > 255) ? 255 : mag;
        return {3{m[7:0]}};
`else
        m = 0;
        return (mag >= TH) ? 24'hFFFFFF : 24'h000000;
`endif
    endfunction

    function automatic logic [7:0] pix_of(input int mode, input int c);
        case (mode)
            0:       return 8'h80;
            1:       return (c >= 4) ? 8'd255 : 8'd0;
            3:       return (c >= 4) ? 8'd40 : 8'd0;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic idle(input int n);
        src_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] p);
        exp_t e;
        src_valid  = 1'b1;
        src_data   = {16'($urandom), p};
        img[mr][mc] = int'(p);
        e.data = ref_pix(mr, mc);
        e.t    = cyc + LAT;
        exp_q.push_back(e);
        if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
        @(posedge clk);
        #1;
        src_valid = 1'b0;
    endtask

    task automatic run_frame(input int mode, input int gap);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send(pix_of(mode, c));
                if (gap == 1) idle(2);
                else if (gap == 2) idle($urandom_range(0, 2));
            end
        end
    endtask

    // Output monitor: every dst_valid must match the head of the expected queue on time.
    always @(negedge clk) begin : mon
        exp_t e;
        if (dst_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("data", dst_data, e.data);
                check("latency", cyc, e.t);
                outs.push_back(dst_data);
            end
        end else if (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
            check("missing_valid", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", dst_valid, 0);
        check("reset_data", dst_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_frame(0, 0);
        idle(8);
        check("flat_count", outs.size(), W*H);

        outs.delete();
        run_frame(1, 0);
        idle(8);
        check("step_count", outs.size(), W*H);
        ref_seq = outs;
        check("step_edge_c4", ref_seq[2*W+4], 24'hFFFFFF);
        check("step_edge_c5", ref_seq[5*W+5], 24'hFFFFFF);
        check("step_flat_c6", ref_seq[3*W+6], 24'h0);
        check("step_row1", ref_seq[1*W+4], 24'h0);

        outs.delete();
        run_frame(1, 1);
        idle(8);
        check("gap_count", outs.size(), W*H);
        for (int i = 0; i < W*H; i++) check("gap_seq", outs[i], ref_seq[i]);

        outs.delete();
        run_frame(1, 0);
        run_frame(1, 0);
        idle(8);
        check("b2b_count", outs.size(), 2*W*H);
        for (int i = 0; i < W*H; i++) check("b2b_frame2", outs[W*H+i], ref_seq[i]);

        run_frame(2, 2);
        run_frame(2, 0);
        idle(8);

        for (int i = 0; i < 20; i++) send(8'($urandom));
        rst       = 1'b1;
        src_valid = 1'b1;
        src_data  = 24'($urandom);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        src_valid = 1'b0;
        exp_q.delete();
        mr = 0;
        mc = 0;
        @(negedge clk);
        check("post_rst_valid", dst_valid, 0);
        check("post_rst_data", dst_data, 0);
        outs.delete();
        run_frame(2, 2);
        idle(8);
        check("post_rst_count", outs.size(), W*H);

        outs.delete();
        run_frame(3, 0);
        idle(8);
`ifdef SOBEL_MAG_OUT_EN
        check("step40_edge", outs[2*W+4], 24'hA0A0A0);
`else
        check("step40_edge", outs[2*W+4], 24'hFFFFFF);
`endif
        check("leftover", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
